// File: rtl/flasher_pkg.sv
// rtl/flasher_pkg.sv - shared types and default phase table for the bounded flasher
package flasher_pkg;

    // Entry bound is stored wide enough for the largest supported LED count (64).
    localparam int BOUND_W = 7;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        dir_e               dir;
        logic [BOUND_W-1:0] bound;
        logic               kick;
    } phase_entry_t;

    // Power-up program; bounds above the LED count are clamped to it.
    function automatic phase_entry_t default_entry(input int idx, input int n_leds);
        phase_entry_t e;
        int           b;
        case (idx)
            0:       begin e.dir = UP;   b = 16; e.kick = 1'b0; end
            1:       begin e.dir = DOWN; b = 5;  e.kick = 1'b1; end
            2:       begin e.dir = UP;   b = 11; e.kick = 1'b0; end
            3:       begin e.dir = DOWN; b = 0;  e.kick = 1'b1; end
            4:       begin e.dir = UP;   b = 6;  e.kick = 1'b0; end
            default: begin e.dir = DOWN; b = 0;  e.kick = 1'b0; end
        endcase
        if (b > n_leds) begin
            b = n_leds;
        end
        e.bound = BOUND_W'(b);
        return e;
    endfunction

endpackage

// File: rtl/prog_bound_flasher_if.sv
// rtl/prog_bound_flasher_if.sv - control, config and display bundle of the flasher
interface prog_bound_flasher_if #(
    parameter int N_LEDS   = 16,
    parameter int N_PHASES = 6
);
    localparam int CW = $clog2(N_LEDS + 1);
    localparam int PW = $clog2(N_PHASES);

    logic              flick;
    logic              tick;
    logic              repeat_en;
    logic              cfg_we;
    logic [PW-1:0]     cfg_addr;
    logic              cfg_dir;
    logic [CW-1:0]     cfg_bound;
    logic              cfg_kick;
    logic [N_LEDS-1:0] leds;
    logic              busy;
    logic [PW-1:0]     phase_idx;
    logic              done;
    logic              cfg_err;

    modport master (
        output flick, tick, repeat_en, cfg_we, cfg_addr, cfg_dir, cfg_bound, cfg_kick,
        input  leds, busy, phase_idx, done, cfg_err
    );

    modport slave (
        input  flick, tick, repeat_en, cfg_we, cfg_addr, cfg_dir, cfg_bound, cfg_kick,
        output leds, busy, phase_idx, done, cfg_err
    );

endinterface

// File: rtl/flash_counter.sv
// rtl/flash_counter.sv - saturating up/down LED count with clear and load
module flash_counter #(
    parameter  int N_LEDS = 16,
    localparam int CW     = $clog2(N_LEDS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_up,
    input  logic          i_dn,
    output logic [CW-1:0] o_count
);
    localparam logic [CW-1:0] MAXC = CW'(N_LEDS);

    logic [CW-1:0] r_count;

    // Clear beats load beats step; steps stop at 0 and N_LEDS instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= (i_load_val > MAXC) ? MAXC : i_load_val;
        end else if (i_up && (r_count != MAXC)) begin
            r_count <= r_count + 1'b1;
        end else if (i_dn && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/prog_bound_flasher.sv
// rtl/prog_bound_flasher.sv - phase-table driven thermometer LED flasher
module prog_bound_flasher
    import flasher_pkg::*;
#(
    parameter int N_LEDS   = 16,
    parameter int N_PHASES = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prog_bound_flasher_if.slave   bus
);
    localparam int CW = $clog2(N_LEDS + 1);
    localparam int PW = $clog2(N_PHASES);

    localparam logic [CW-1:0] MAXC    = CW'(N_LEDS);
    localparam logic [PW:0]   PH_LIM  = (PW + 1)'(N_PHASES);
    localparam logic [PW-1:0] PH_LAST = PW'(N_PHASES - 1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          r_cfg_err;
    phase_entry_t  r_table [N_PHASES];

    logic          w_cfg_ok;
    logic [CW-1:0] w_cfg_bound;
    phase_entry_t  w_entry;
    logic [CW-1:0] w_bound;
    logic [CW-1:0] w_prev_bound;
    logic [CW-1:0] w_count;
    logic          w_clr;
    logic          w_load;
    logic          w_up;
    logic          w_dn;
    logic [N_LEDS-1:0] w_leds;

    function automatic logic [CW-1:0] fit_bound(input logic [BOUND_W-1:0] b);
        return (b > BOUND_W'(N_LEDS)) ? MAXC : b[CW-1:0];
    endfunction

    assign w_cfg_ok     = bus.cfg_we && (r_state == IDLE) && ({1'b0, bus.cfg_addr} < PH_LIM);
    assign w_cfg_bound  = (bus.cfg_bound > MAXC) ? MAXC : bus.cfg_bound;
    assign w_entry      = r_table[r_phase];
    assign w_bound      = fit_bound(w_entry.bound);
    assign w_prev_bound = (r_phase == '0) ? MAXC : fit_bound(r_table[r_phase - 1'b1].bound);

    // Phase table: defaults on reset, otherwise written only by accepted config strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < N_PHASES; p++) begin
                r_table[p] <= default_entry(p, N_LEDS);
            end
        end else if (w_cfg_ok) begin
            r_table[bus.cfg_addr] <= '{dir: dir_e'(bus.cfg_dir), bound: BOUND_W'(w_cfg_bound), kick: bus.cfg_kick};
        end
    end

    // State, phase and the two one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_phase   <= '0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_done    <= w_done_nxt;
            r_cfg_err <= bus.cfg_we && !w_cfg_ok;
        end
    end

    // Sequencer: step toward the bound, then kick back, advance, wrap or finish.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_done_nxt  = 1'b0;
        w_clr       = 1'b0;
        w_load      = 1'b0;
        w_up        = 1'b0;
        w_dn        = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr       = 1'b1;
                w_phase_nxt = '0;
                if (bus.flick) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.tick) begin
                    if ((w_entry.dir == UP) && (w_count < w_bound)) begin
                        w_up = 1'b1;
                    end else if ((w_entry.dir == DOWN) && (w_count > w_bound)) begin
                        w_dn = 1'b1;
                    end else if ((w_entry.dir == DOWN) && w_entry.kick && bus.flick) begin
                        w_load = 1'b1;
                    end else if (r_phase != PH_LAST) begin
                        w_phase_nxt = r_phase + 1'b1;
                    end else if (bus.repeat_en && bus.flick) begin
                        w_phase_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_phase_nxt = '0;
                        w_clr       = 1'b1;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    flash_counter #(
        .N_LEDS (N_LEDS)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_load     (w_load),
        .i_load_val (w_prev_bound),
        .i_up       (w_up),
        .i_dn       (w_dn),
        .o_count    (w_count)
    );

    // Thermometer decode straight from the count register.
    always_comb begin
        w_leds = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            w_leds[i] = (i < int'(w_count));
        end
    end

    assign bus.leds      = w_leds;
    assign bus.busy      = (r_state == RUN);
    assign bus.phase_idx = r_phase;
    assign bus.done      = r_done;
    assign bus.cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_prog_bound_flasher.sv
// tb/tb_prog_bound_flasher.sv - directed vector bench for prog_bound_flasher
module tb_prog_bound_flasher;

    localparam int N_LEDS   = 16;
    localparam int N_PHASES = 6;

    typedef struct {
        bit rst;
        bit flick;
        bit tick;
        bit rep;
        int n;
        int cnt;
        int ph;
        bit busy;
        bit done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    prog_bound_flasher_if #(.N_LEDS(N_LEDS), .N_PHASES(N_PHASES)) bus ();

    prog_bound_flasher #(.N_LEDS(N_LEDS), .N_PHASES(N_PHASES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [N_LEDS-1:0] therm(input int c);
        logic [63:0] t;
        t = (64'd1 << c) - 64'd1;
        return t[N_LEDS-1:0];
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic void add(input bit rst, input bit flick, input bit tick, input bit rep,
                                input int n, input int cnt, input int ph, input bit busy, input bit done);
        vec_t v;
        v.rst = rst; v.flick = flick; v.tick = tick; v.rep = rep; v.n = n;
        v.cnt = cnt; v.ph = ph; v.busy = busy; v.done = done;
        vecs.push_back(v);
    endfunction

    task automatic clear_inputs();
        bus.flick = 1'b0; bus.tick = 1'b0; bus.repeat_en = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_addr = '0; bus.cfg_dir = 1'b0; bus.cfg_bound = '0; bus.cfg_kick = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        bus.flick = 1'b1; bus.tick = 1'b1;
        step(1);
        bus.flick = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input bit dir, input int bound, input bit kick);
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'(addr); bus.cfg_dir = dir;
        bus.cfg_bound = 5'(bound); bus.cfg_kick = kick;
        step(1);
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit found = 1'b0;
        bus.tick = 1'b1;
        for (int i = 0; i < 300 && !found; i++) begin
            step(1);
            if (bus.done) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    task automatic measure(input bit alt, output int cycles, output int viol);
        logic [N_LEDS-1:0] prev;
        bit fin = 1'b0;
        cycles = 0;
        viol = 0;
        do_reset();
        start_run();
        while (!fin && cycles < 400) begin
            bus.tick = alt ? cycles[0] : 1'b1;
            prev = bus.leds;
            step(1);
            cycles++;
            if (alt && !bus.tick && bus.leds != prev) viol++;
            if (bus.done) fin = 1'b1;
        end
        if (!fin) cycles = -1;
    endtask

    initial begin
        int cyc;
        int viol;
        clear_inputs();

        // Full default sequence, one-cycle flick.
        add(1, 0, 1, 0, 1,  0, 0, 0, 0);
        add(0, 1, 1, 0, 1,  0, 0, 1, 0);
        add(0, 0, 1, 0, 1,  1, 0, 1, 0);
        add(0, 0, 1, 0, 15, 16, 0, 1, 0);
        add(0, 0, 1, 0, 1,  16, 1, 1, 0);
        add(0, 0, 1, 0, 11, 5, 1, 1, 0);
        add(0, 0, 1, 0, 1,  5, 2, 1, 0);
        add(0, 0, 1, 0, 6,  11, 2, 1, 0);
        add(0, 0, 1, 0, 1,  11, 3, 1, 0);
        add(0, 0, 1, 0, 11, 0, 3, 1, 0);
        add(0, 0, 1, 0, 1,  0, 4, 1, 0);
        add(0, 0, 1, 0, 6,  6, 4, 1, 0);
        add(0, 0, 1, 0, 1,  6, 5, 1, 0);
        add(0, 0, 1, 0, 6,  0, 5, 1, 0);
        add(0, 0, 1, 0, 1,  0, 0, 0, 1);
        add(0, 0, 1, 0, 1,  0, 0, 0, 0);
        // Kickback at phase 1 (reload 16) and phase 3 (reload 11).
        add(1, 1, 1, 0, 1,  0, 0, 1, 0);
        add(0, 0, 1, 0, 16, 16, 0, 1, 0);
        add(0, 0, 1, 0, 1,  16, 1, 1, 0);
        add(0, 0, 1, 0, 11, 5, 1, 1, 0);
        add(0, 1, 1, 0, 1,  16, 1, 1, 0);
        add(0, 1, 1, 0, 1,  15, 1, 1, 0);
        add(0, 0, 1, 0, 10, 5, 1, 1, 0);
        add(0, 0, 1, 0, 1,  5, 2, 1, 0);
        add(0, 0, 1, 0, 7,  11, 3, 1, 0);
        add(0, 0, 1, 0, 11, 0, 3, 1, 0);
        add(0, 1, 1, 0, 1,  11, 3, 1, 0);
        // Repeat: flick held at the end of phase 5 wraps to phase 0.
        add(1, 1, 1, 1, 1,  0, 0, 1, 0);
        add(0, 0, 1, 1, 17, 16, 1, 1, 0);
        add(0, 0, 1, 1, 12, 5, 2, 1, 0);
        add(0, 0, 1, 1, 7,  11, 3, 1, 0);
        add(0, 0, 1, 1, 12, 0, 4, 1, 0);
        add(0, 0, 1, 1, 7,  6, 5, 1, 0);
        add(0, 0, 1, 1, 6,  0, 5, 1, 0);
        add(0, 1, 1, 1, 1,  0, 0, 1, 0);
        add(0, 0, 1, 1, 1,  1, 0, 1, 0);

        // Reset state.
        rst_n = 1'b0;
        #12;
        check("rst_leds", bus.leds, 0);
        check("rst_phase", bus.phase_idx, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            bus.flick = vecs[k].flick;
            bus.tick = vecs[k].tick;
            bus.repeat_en = vecs[k].rep;
            step(vecs[k].n);
            check($sformatf("v%0d_leds", k), bus.leds, therm(vecs[k].cnt));
            check($sformatf("v%0d_phase", k), bus.phase_idx, vecs[k].ph);
            check($sformatf("v%0d_busy", k), bus.busy, vecs[k].busy);
            check($sformatf("v%0d_done", k), bus.done, vecs[k].done);
        end

        // Tick every other cycle doubles the run length and never steps on tick=0.
        measure(1'b0, cyc, viol);
        check("dur_full", cyc, 62);
        measure(1'b1, cyc, viol);
        check("dur_alt", cyc, 124);
        check("hold_tick0", viol, 0);

        // Bound saturation on write, rejected write in RUN.
        do_reset();
        cfg_write(0, 1'b0, 20, 1'b0);
        check("cfg_ok_err", bus.cfg_err, 0);
        start_run();
        bus.tick = 1'b1;
        step(16);
        check("sat_cnt", bus.leds, therm(16));
        step(1);
        check("sat_adv", bus.phase_idx, 1);
        bus.tick = 1'b0;
        cfg_write(0, 1'b0, 3, 1'b0);
        check("run_wr_err", bus.cfg_err, 1);
        check("run_wr_hold", bus.leds, therm(16));
        step(1);
        check("err_pulse", bus.cfg_err, 0);
        wait_done("done1");
        step(1);
        start_run();
        bus.tick = 1'b1;
        step(17);
        check("unchanged_cnt", bus.leds, therm(16));
        check("unchanged_ph", bus.phase_idx, 1);
        wait_done("done2");
        step(1);
        cfg_write(7, 1'b0, 3, 1'b0);
        check("bad_addr_err", bus.cfg_err, 1);

        // Write and flick in the same IDLE cycle: new entry used immediately.
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_dir = 1'b0;
        bus.cfg_bound = 5'd4; bus.cfg_kick = 1'b0;
        bus.flick = 1'b1; bus.tick = 1'b1;
        step(1);
        bus.cfg_we = 1'b0; bus.flick = 1'b0;
        check("wf_busy", bus.busy, 1);
        check("wf_err", bus.cfg_err, 0);
        step(4);
        check("wf_cnt", bus.leds, therm(4));
        step(1);
        check("wf_adv", bus.phase_idx, 1);
        step(1);
        check("wrongdir_adv", bus.phase_idx, 2);
        check("wrongdir_cnt", bus.leds, therm(4));
        step(1);
        check("ph2_cnt", bus.leds, therm(5));

        // Asynchronous reset mid-phase 2.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_leds", bus.leds, 0);
        check("arst_phase", bus.phase_idx, 0);
        check("arst_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_inputs();
        start_run();
        bus.tick = 1'b1;
        step(17);
        check("dflt_cnt", bus.leds, therm(16));
        check("dflt_ph", bus.phase_idx, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
